// File: rtl/paicore_send_ctrl.sv
// paicore_send_ctrl: sequences one send job (length latch, word counters, idle timeout, abort)
module paicore_send_ctrl #(
  parameter int TO_W = 32
) (
  input  logic            s_axis_aclk,
  input  logic            s_axis_aresetn,
  input  logic            cfg_start,
  input  logic [31:0]     cfg_len,
  input  logic [TO_W-1:0] cfg_timeout,
  input  logic            cfg_abort,
  output logic [31:0]     send_len,
  output logic            dp_enable,
  output logic            dp_flush,
  input  logic            write_hsked,
  input  logic            snn_in_hsked,
  input  logic            o_tx_done,
  output logic            busy,
  output logic            done,
  output logic            err_timeout,
  output logic            err_abort,
  output logic            err_zero_len,
  output logic [31:0]     in_cnt,
  output logic [31:0]     out_cnt
);
  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE, ERR} state_t;
  state_t state_q, state_d;
  logic [31:0] send_len_q, send_len_d, in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
  logic [TO_W-1:0] idle_q, idle_d;
  logic tx_seen_q, tx_seen_d, busy_q, busy_d, dp_enable_q, dp_enable_d;
  logic dp_flush_q, dp_flush_d, done_q, done_d;
  logic err_timeout_q, err_timeout_d, err_abort_q, err_abort_d, err_zero_len_q, err_zero_len_d;
  logic active, timeout, abort;
  always_comb begin
    active = state_q == RUN || state_q == DRAIN;
    state_d = state_q;
    send_len_d = send_len_q;
    err_timeout_d = err_timeout_q;
    err_abort_d = err_abort_q;
    err_zero_len_d = err_zero_len_q;
    in_cnt_d = (state_q == RUN && write_hsked && in_cnt_q != '1) ? in_cnt_q + 32'd1 : in_cnt_q;
    out_cnt_d = (active && snn_in_hsked && out_cnt_q != '1) ? out_cnt_q + 32'd1 : out_cnt_q;
    idle_d = !active ? idle_q : (write_hsked || snn_in_hsked) ? '0 :
             (idle_q != '1) ? idle_q + TO_W'(1) : idle_q;
    tx_seen_d = (state_q == LOAD) ? 1'b0 : tx_seen_q || (active && o_tx_done);
    timeout = active && cfg_timeout != '0 && idle_d >= cfg_timeout;
    abort = cfg_abort && (state_q == LOAD || active);
    case (state_q)
      IDLE: if (cfg_start) begin
        if (cfg_len != 32'd0) begin
          state_d = LOAD;
          send_len_d = cfg_len;
          err_timeout_d = 1'b0;
          err_abort_d = 1'b0;
          err_zero_len_d = 1'b0;
        end else err_zero_len_d = 1'b1;
      end
      LOAD: begin
        state_d = RUN;
        in_cnt_d = '0;
        out_cnt_d = '0;
        idle_d = '0;
      end
      RUN: if (write_hsked && in_cnt_d == send_len_q) state_d = DRAIN;
      // completion counts this cycle's handshake and tx_done pulse
      DRAIN: if (out_cnt_d == send_len_q && (tx_seen_q || o_tx_done)) state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = ERR;
      err_abort_d = 1'b1;
    end else if (timeout) begin
      state_d = ERR;
      err_timeout_d = 1'b1;
    end
    busy_d = state_d inside {LOAD, RUN, DRAIN};
    dp_enable_d = state_d == RUN;
    done_d = state_d == DONE;
    dp_flush_d = state_d == ERR;
  end
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state_q <= IDLE;
      send_len_q <= '0;
      in_cnt_q <= '0;
      out_cnt_q <= '0;
      idle_q <= '0;
      tx_seen_q <= 1'b0;
      busy_q <= 1'b0;
      dp_enable_q <= 1'b0;
      dp_flush_q <= 1'b0;
      done_q <= 1'b0;
      err_timeout_q <= 1'b0;
      err_abort_q <= 1'b0;
      err_zero_len_q <= 1'b0;
    end else begin
      state_q <= state_d;
      send_len_q <= send_len_d;
      in_cnt_q <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      idle_q <= idle_d;
      tx_seen_q <= tx_seen_d;
      busy_q <= busy_d;
      dp_enable_q <= dp_enable_d;
      dp_flush_q <= dp_flush_d;
      done_q <= done_d;
      err_timeout_q <= err_timeout_d;
      err_abort_q <= err_abort_d;
      err_zero_len_q <= err_zero_len_d;
    end
  end
  assign send_len = send_len_q;
  assign in_cnt = in_cnt_q;
  assign out_cnt = out_cnt_q;
  assign busy = busy_q;
  assign dp_enable = dp_enable_q;
  assign dp_flush = dp_flush_q;
  assign done = done_q;
  assign err_timeout = err_timeout_q;
  assign err_abort = err_abort_q;
  assign err_zero_len = err_zero_len_q;
endmodule

// File: tb/tb_paicore_send_ctrl.sv
// tb_paicore_send_ctrl: job table driven through the controller, results checked via a scoreboard queue
module tb_paicore_send_ctrl;
  logic clk, rst_n, cfg_start, cfg_abort, write_hsked, snn_in_hsked, o_tx_done;
  logic [31:0] cfg_len, cfg_timeout, send_len, in_cnt, out_cnt;
  logic dp_enable, dp_flush, busy, done, err_timeout, err_abort, err_zero_len;
  int checks = 0, errors = 0;

  typedef struct {
    logic [31:0] len, to;
    int nin, olo, ohi, tx, ab, rs;
    int done, flush, en, busy, zl, tout, abt;
    logic [31:0] in, out, sl;
  } vec_t;
  vec_t tbl[9];
  vec_t sb[$];

  paicore_send_ctrl #(.TO_W(32)) dut (
    .s_axis_aclk(clk), .s_axis_aresetn(rst_n), .cfg_start(cfg_start), .cfg_len(cfg_len),
    .cfg_timeout(cfg_timeout), .cfg_abort(cfg_abort), .send_len(send_len), .dp_enable(dp_enable),
    .dp_flush(dp_flush), .write_hsked(write_hsked), .snn_in_hsked(snn_in_hsked), .o_tx_done(o_tx_done),
    .busy(busy), .done(done), .err_timeout(err_timeout), .err_abort(err_abort),
    .err_zero_len(err_zero_len), .in_cnt(in_cnt), .out_cnt(out_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_en"}, 32'(dp_enable), 32'd0);
    chk({tag, "_flush"}, 32'(dp_flush), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_errs"}, {29'd0, err_timeout, err_abort, err_zero_len}, 32'd0);
    chk({tag, "_in"}, in_cnt, 32'd0);
    chk({tag, "_out"}, out_cnt, 32'd0);
    chk({tag, "_sl"}, send_len, 32'd0);
  endtask

  task automatic run_job(input vec_t v, input int k);
    int nd, nf, ne, nb;
    vec_t e;
    string t;
    nd = 0; nf = 0; ne = 0; nb = 0;
    sb.push_back(v);
    cfg_start = 1'b1; cfg_len = v.len; cfg_timeout = v.to;
    tick();
    cfg_start = 1'b0;
    nb += int'(busy);
    tick();
    for (int i = 0; i < 40; i++) begin
      write_hsked = i < v.nin;
      snn_in_hsked = i >= v.olo && i < v.ohi;
      o_tx_done = i == v.tx;
      cfg_abort = i == v.ab;
      cfg_start = i == v.rs;
      cfg_len = (i == v.rs) ? 32'd99 : v.len;
      ne += int'(dp_enable);
      tick();
      nd += int'(done);
      nf += int'(dp_flush);
      nb += int'(busy);
    end
    {write_hsked, snn_in_hsked, o_tx_done, cfg_abort, cfg_start} = '0;
    e = sb.pop_front();
    t = $sformatf("job%0d", k);
    chk({t, "_done_pulses"}, 32'(nd), 32'(e.done));
    chk({t, "_flush_pulses"}, 32'(nf), 32'(e.flush));
    chk({t, "_en_cycles"}, 32'(ne), 32'(e.en));
    chk({t, "_busy_seen"}, 32'(nb != 0), 32'(e.busy));
    chk({t, "_busy_end"}, 32'(busy), 32'd0);
    chk({t, "_err_zero_len"}, 32'(err_zero_len), 32'(e.zl));
    chk({t, "_err_timeout"}, 32'(err_timeout), 32'(e.tout));
    chk({t, "_err_abort"}, 32'(err_abort), 32'(e.abt));
    chk({t, "_in_cnt"}, in_cnt, e.in);
    chk({t, "_out_cnt"}, out_cnt, e.out);
    chk({t, "_send_len"}, send_len, e.sl);
  endtask

  initial begin
    //        len    to  nin olo ohi tx  ab  rs  done fl en busy zl to ab  in  out  sl
    tbl[0] = '{32'd4, 32'd0, 4, 0, 4, 4, -1, -1, 1, 0, 4, 1, 0, 0, 0, 32'd4, 32'd4, 32'd4};
    tbl[1] = '{32'd0, 32'd0, 0, 0, 0, -1, -1, -1, 0, 0, 0, 0, 1, 0, 0, 32'd4, 32'd4, 32'd4};
    tbl[2] = '{32'd8, 32'd10, 3, 0, 3, -1, -1, -1, 0, 1, 13, 1, 0, 1, 0, 32'd3, 32'd3, 32'd8};
    tbl[3] = '{32'd4, 32'd0, 4, 0, 4, 4, 4, -1, 0, 1, 4, 1, 0, 0, 1, 32'd4, 32'd4, 32'd4};
    tbl[4] = '{32'd3, 32'd0, 3, 0, 3, 1, -1, -1, 1, 0, 3, 1, 0, 0, 0, 32'd3, 32'd3, 32'd3};
    tbl[5] = '{32'd2, 32'd0, 2, 3, 5, 6, -1, -1, 1, 0, 2, 1, 0, 0, 0, 32'd2, 32'd2, 32'd2};
    tbl[6] = '{32'd2, 32'd3, 2, 2, 3, -1, -1, -1, 0, 1, 2, 1, 0, 1, 0, 32'd2, 32'd1, 32'd2};
    tbl[7] = '{32'd4, 32'd0, 4, 0, 4, 4, -1, 1, 1, 0, 4, 1, 0, 0, 0, 32'd4, 32'd4, 32'd4};
    tbl[8] = '{32'd4, 32'd0, 2, 0, 2, -1, 5, -1, 0, 1, 6, 1, 0, 0, 1, 32'd2, 32'd2, 32'd4};
    rst_n = 1'b0;
    {cfg_start, cfg_abort, write_hsked, snn_in_hsked, o_tx_done} = '0;
    cfg_len = '0; cfg_timeout = '0;
    #2;
    all_zero("reset");
    #10 rst_n = 1'b1;
    for (int k = 0; k < 9; k++) run_job(tbl[k], k);
    // asynchronous reset in the middle of RUN, then a clean job right after release
    cfg_start = 1'b1; cfg_len = 32'd4; cfg_timeout = 32'd0;
    tick();
    cfg_start = 1'b0;
    tick();
    write_hsked = 1'b1;
    tick();
    tick();
    write_hsked = 1'b0;
    chk("pre_rst_in_cnt", in_cnt, 32'd2);
    chk("pre_rst_en", 32'(dp_enable), 32'd1);
    #3 rst_n = 1'b0;
    #1 all_zero("mid_rst");
    tick();
    tick();
    #2 rst_n = 1'b1;
    run_job(tbl[0], 9);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/paicore_send_ctrl.md
PAICORE_SEND_CTRL -- requirements
Module: paicore_send_ctrl

Interface
REQ-001 SHALL have parameter TO_W, default 32, width of the timeout field and idle counter.
REQ-002 SHALL have port s_axis_aclk  in  1  sole clock; all logic is rising-edge.
REQ-003 SHALL have port s_axis_aresetn  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port cfg_start  in  1  single-cycle job start request.
REQ-005 SHALL have port cfg_len  in  32  job length in 64-bit words, sampled on an accepted cfg_start.
REQ-006 SHALL have port cfg_timeout  in  TO_W  idle-cycle limit; 0 disables the timeout.
REQ-007 SHALL have port cfg_abort  in  1  single-cycle abort request.
REQ-008 SHALL have port send_len  out  32  length driven to the send datapath.
REQ-009 SHALL have port dp_enable  out  1  gates the DMA input stream into the send datapath.
REQ-010 SHALL have port dp_flush  out  1  single-cycle flush pulse to the datapath FIFO and counters.
REQ-011 SHALL have port write_hsked  in  1  input-word handshake from the send datapath.
REQ-012 SHALL have port snn_in_hsked  in  1  word handshake into the chip-side sender.
REQ-013 SHALL have port o_tx_done  in  1  transmit-complete pulse from the datapath.
REQ-014 SHALL have port busy  out  1  high in LOAD, RUN and DRAIN.
REQ-015 SHALL have port done  out  1  single-cycle job-complete pulse.
REQ-016 SHALL have port err_timeout, err_abort, err_zero_len  out  1 each  sticky error flags.
REQ-017 SHALL have port in_cnt, out_cnt  out  32 each  per-job write_hsked and snn_in_hsked counts.

Function
REQ-018 SHALL implement states IDLE, LOAD, RUN, DRAIN, DONE, ERR.
REQ-019 IDLE: cfg_start with cfg_len!=0 -> LOAD; all three error flags clear.
REQ-020 IDLE: cfg_start with cfg_len==0 -> set err_zero_len; stay IDLE; no done pulse.
REQ-021 cfg_start SHALL be ignored outside IDLE.
REQ-022 LOAD: lasts one cycle; latches send_len=cfg_len; zeroes in_cnt, out_cnt and the idle counter; -> RUN.
REQ-023 RUN: dp_enable=1; each write_hsked increments in_cnt.
REQ-024 RUN: the cycle the increment makes in_cnt==send_len -> DRAIN; dp_enable drops in the next cycle.
REQ-025 write_hsked SHALL be counted only in RUN.
REQ-026 snn_in_hsked SHALL increment out_cnt in RUN and DRAIN.
REQ-027 An o_tx_done pulse in RUN or DRAIN SHALL set an internal tx_seen flag; LOAD clears it.
REQ-028 DRAIN: dp_enable=0; -> DONE when out_cnt==send_len and tx_seen, including the current cycle's snn_in_hsked and o_tx_done.
REQ-029 DONE: done=1 for exactly one cycle; -> IDLE; send_len, in_cnt and out_cnt hold their values.
REQ-030 Idle counter increments each RUN/DRAIN cycle with neither handshake; either handshake clears it.
REQ-031 If cfg_timeout!=0 and the idle counter reaches cfg_timeout, SHALL set err_timeout and -> ERR.
REQ-032 cfg_abort in LOAD, RUN or DRAIN SHALL set err_abort and -> ERR; cfg_abort in IDLE, DONE or ERR is ignored.
REQ-033 Same-cycle priority: abort > timeout > completion.
REQ-034 ERR: dp_flush=1 for one cycle; dp_enable=0; -> IDLE; no done pulse.
REQ-035 Counters SHALL saturate at 0xFFFFFFFF and never wrap.
REQ-036 All outputs SHALL be registered.

Reset
REQ-037 Asserting s_axis_aresetn low SHALL force IDLE immediately; all outputs and counters 0; send_len 0.
REQ-038 Reset mid-job SHALL drop the job with no done and no dp_flush pulse.
REQ-039 The first cfg_start SHALL be accepted on the first clock edge after reset deasserts.

Verification
REQ-040 Normal job: len=4, four write_hsked, four snn_in_hsked, o_tx_done -> one done pulse; in_cnt=out_cnt=4; dp_enable high only during RUN.
REQ-041 Zero length: cfg_start with len=0 -> err_zero_len=1; busy stays 0; no done pulse.
REQ-042 Timeout: cfg_timeout=10, len=8, stall after 3 words -> err_timeout after 10 idle cycles; one dp_flush pulse; state IDLE.
REQ-043 Abort and completion in the same cycle of DRAIN -> err_abort=1; done stays 0.
REQ-044 Second cfg_start during RUN -> ignored; send_len unchanged; the first job completes normally.
REQ-045 Asynchronous reset mid-RUN with in_cnt=2 -> all outputs 0 before the next clock edge; a new job then runs cleanly.
